// File: rtl/mux_nx1_reg.sv
// N-channel, W-bit registered selector: fixed or round-robin choice of one valid/ready
// producer into a one-entry output register. Build macro MUX_SEL_CHECK_EN adds sticky sel_err.

// Handshake invariants of the selector output stage.
module mux_nx1_reg_chk #(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int SW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    in_ready,
    input  logic [W-1:0]    out_data,
    input  logic            out_valid,
    input  logic            out_ready,
    input  logic [SW-1:0]   out_chan
);

    // A stalled, full output register must hold its word and channel
    property p_hold;
        @(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_chan));
    endproperty

    a_hold: assert property (p_hold);

    // At most one producer is ever offered the slot
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));

endmodule

module mux_nx1_reg #(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int SW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_chan
`ifdef MUX_SEL_CHECK_EN
    ,
    output logic            sel_err
`endif
);

    localparam logic          ST_EMPTY = 1'b0;
    localparam logic          ST_FULL  = 1'b1;
    localparam logic [SW:0]   N_L      = (SW+1)'(N);
    localparam logic [SW-1:0] LAST_L   = SW'(N - 1);
    localparam logic [SW-1:0] ONE_L    = {{(SW-1){1'b0}}, 1'b1};

    logic            state_r;
    logic [W-1:0]    out_data_r;
    logic [SW-1:0]   out_chan_r;
    logic [SW-1:0]   ptr_r;

    logic            load_en_s;
    logic            sel_ok_s;
    logic            rr_ok_s;
    logic [SW-1:0]   rr_idx_s;
    logic [SW:0]     scan_s;
    logic [SW:0]     wrap_s;
    logic            hit_s;
    logic            cand_ok_s;
    logic [SW-1:0]   cand_s;
    logic [N-1:0]    in_ready_s;
    logic            load_s;
    logic [W-1:0]    cand_data_s;
    logic [SW-1:0]   ptr_next_s;

    assign load_en_s   = (state_r == ST_EMPTY) || out_ready;
    assign load_s      = cand_ok_s && in_valid[cand_s] && load_en_s;
    assign cand_data_s = in_data[int'(cand_s) * W +: W];
    assign ptr_next_s  = (cand_s == LAST_L) ? {SW{1'b0}} : (cand_s + ONE_L);

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_valid = state_r;
    assign out_chan  = out_chan_r;

    // Fixed-mode candidate exists only when sel names a real channel
    always_comb begin
        sel_ok_s = 1'b0;
        if ({1'b0, sel} < N_L) begin
            sel_ok_s = 1'b1;
        end else begin
            sel_ok_s = 1'b0;
        end
    end

    // Round-robin scan: first valid channel at or after ptr, wrapping N-1 -> 0
    always_comb begin
        rr_ok_s  = 1'b0;
        rr_idx_s = {SW{1'b0}};
        scan_s   = {(SW+1){1'b0}};
        wrap_s   = {(SW+1){1'b0}};
        hit_s    = 1'b0;
        for (int k = 0; k < N; k++) begin
            scan_s   = {1'b0, ptr_r} + (SW+1)'(k);
            wrap_s   = (scan_s >= N_L) ? (scan_s - N_L) : scan_s;
            hit_s    = !rr_ok_s && in_valid[wrap_s[SW-1:0]];
            rr_idx_s = hit_s ? wrap_s[SW-1:0] : rr_idx_s;
            rr_ok_s  = rr_ok_s || hit_s;
        end
    end

    // Merge the two modes into one candidate and offer it the load slot
    always_comb begin
        cand_ok_s  = 1'b0;
        cand_s     = {SW{1'b0}};
        in_ready_s = {N{1'b0}};
        if (mode) begin
            cand_ok_s = rr_ok_s;
            cand_s    = rr_idx_s;
        end else begin
            cand_ok_s = sel_ok_s;
            cand_s    = sel_ok_s ? sel : {SW{1'b0}};
        end
        if (cand_ok_s) begin
            in_ready_s[cand_s] = load_en_s;
        end else begin
            in_ready_s = {N{1'b0}};
        end
    end

    // Output-stage occupancy: EMPTY/FULL is what out_valid reports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: state_r <= load_s ? ST_FULL : ST_EMPTY;
                ST_FULL:  state_r <= (out_ready && !load_s) ? ST_EMPTY : ST_FULL;
                default:  state_r <= ST_EMPTY;
            endcase
        end
    end

    // Output data/channel capture; held untouched whenever no load happens
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r <= {W{1'b0}};
            out_chan_r <= {SW{1'b0}};
        end else if (load_s) begin
            out_data_r <= cand_data_s;
            out_chan_r <= cand_s;
        end else begin
            out_data_r <= out_data_r;
            out_chan_r <= out_chan_r;
        end
    end

    // Round-robin pointer advances past the winner only on an RR load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {SW{1'b0}};
        end else if (load_s && mode) begin
            ptr_r <= ptr_next_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

`ifdef MUX_SEL_CHECK_EN
    logic sel_err_r;

    assign sel_err = sel_err_r;

    // Sticky flag for any fixed-mode cycle naming a channel that does not exist
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_r <= 1'b0;
        end else if (!mode && !sel_ok_s) begin
            sel_err_r <= 1'b1;
        end else begin
            sel_err_r <= sel_err_r;
        end
    end
`endif

    mux_nx1_reg_chk #(.N(N), .W(W), .SW(SW)) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_ready  (in_ready_s),
        .out_data  (out_data_r),
        .out_valid (state_r),
        .out_ready (out_ready),
        .out_chan  (out_chan_r)
    );

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Self-checking bench for mux_nx1_reg: directed scenarios plus randomized traffic against
// a behavioural model; a second N=6 instance covers out-of-range fixed selects.
`timescale 1ns/1ps
module tb_mux_nx1_reg;
    localparam int N  = 8;
    localparam int W  = 8;
    localparam int SW = 3;
    localparam int N6 = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_chan;

    logic [N6*W-1:0] d6_in_data;
    logic [N6-1:0]   d6_in_valid;
    logic [N6-1:0]   d6_in_ready;
    logic            d6_mode;
    logic [SW-1:0]   d6_sel;
    logic [W-1:0]    d6_out_data;
    logic            d6_out_valid;
    logic            d6_out_ready;
    logic [SW-1:0]   d6_out_chan;
`ifdef MUX_SEL_CHECK_EN
    logic            sel_err;
    logic            d6_sel_err;
`endif

    int checks   = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    // Behavioural model state
    logic          m_valid;
    logic [W-1:0]  m_data;
    int            m_chan;
    int            m_ptr;
    logic          m_err;
    int            m_cand;
    logic          m_le;
    logic [N-1:0]  exp_ready;

    always #5 clk = ~clk;

    mux_nx1_reg #(.N(N), .W(W), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan)
`ifdef MUX_SEL_CHECK_EN
        , .sel_err(sel_err)
`endif
    );

    mux_nx1_reg #(.N(N6), .W(W), .SW(SW)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_data(d6_in_data), .in_valid(d6_in_valid),
        .in_ready(d6_in_ready), .mode(d6_mode), .sel(d6_sel), .out_data(d6_out_data),
        .out_valid(d6_out_valid), .out_ready(d6_out_ready), .out_chan(d6_out_chan)
`ifdef MUX_SEL_CHECK_EN
        , .sel_err(d6_sel_err)
`endif
    );

    // Which channel may load this cycle, or -1 if none
    function automatic int pick(input logic md, input logic [SW-1:0] s,
                                input logic [N-1:0] v, input int p);
        if (!md) return (int'(s) < N) ? int'(s) : -1;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always_comb m_cand = pick(mode, sel, in_valid, m_ptr);
    always_comb m_le   = !m_valid || out_ready;

    always_comb begin
        exp_ready = '0;
        if (m_cand >= 0) exp_ready[m_cand] = m_le;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_chan  <= 0;
            m_ptr   <= 0;
            m_err   <= 1'b0;
        end else begin
            if (m_cand >= 0 && in_valid[m_cand] && m_le) begin
                m_valid <= 1'b1;
                m_data  <= in_data[m_cand*W +: W];
                m_chan  <= m_cand;
                if (mode) m_ptr <= (m_cand + 1) % N;
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
            if (!mode && int'(sel) >= N) m_err <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("out_valid", 64'(out_valid), 64'(m_valid));
            check("out_data", 64'(out_data), 64'(m_data));
            check("out_chan", 64'(out_chan), 64'(m_chan));
            check("in_ready", 64'(in_ready), 64'(exp_ready));
`ifdef MUX_SEL_CHECK_EN
            check("sel_err", 64'(sel_err), 64'(m_err));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int seq4 [7];
        seq4 = '{2, 6, 2, 6, 2, 2, 2};
        rst_n = 1'b0; mode = 1'b0; sel = '0; out_ready = 1'b1; in_valid = '0;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'h10 + 8'(i);
        d6_mode = 1'b0; d6_sel = '0; d6_out_ready = 1'b1; d6_in_valid = '1;
        for (int i = 0; i < N6; i++) d6_in_data[i*W +: W] = 8'h30 + 8'(i);

        #12;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_chan", 64'(out_chan), 64'd0);
        cmp_en = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;

        // Fixed select stepping through every channel
        in_valid = '1;
        for (int i = 0; i < N; i++) begin
            sel = 3'(i);
            tick();
            check("t1_valid", 64'(out_valid), 64'd1);
            check("t1_data", 64'(out_data), 64'(8'h10 + 8'(i)));
            check("t1_chan", 64'(out_chan), 64'(i));
        end

        // Back-pressure holds the output word
        sel = 3'd3; in_valid = '0;
        tick();
        check("t2_drain", 64'(out_valid), 64'd0);
        in_valid = '1; in_data[3*W +: W] = 8'hA5; out_ready = 1'b0;
        tick();
        check("t2_load", 64'(out_data), 64'hA5);
        check("t2_chan", 64'(out_chan), 64'd3);
        check("t2_rdy_held", 64'(in_ready), 64'd0);
        in_data[3*W +: W] = 8'h5A;
        tick(); tick();
        check("t2_hold", 64'(out_data), 64'hA5);
        check("t2_hold_v", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        #1;
        check("t2_rdy_open", 64'(in_ready), 64'h08);
        tick();
        check("t2_next", 64'(out_data), 64'h5A);

        // Round-robin from reset, all channels valid
        rst_n = 1'b0; mode = 1'b1; in_data[3*W +: W] = 8'h13; in_valid = '1;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i <= N; i++) begin
            tick();
            check("t3_chan", 64'(out_chan), 64'(i % N));
            check("t3_data", 64'(out_data), 64'(8'h10 + 8'(i % N)));
        end

        // Round-robin over a sparse valid set, then a single channel
        in_valid = 8'b0100_0100;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) in_valid = 8'b0000_0100;
            tick();
            check("t4_chan", 64'(out_chan), 64'(seq4[i]));
        end

        // Asynchronous reset while the output is full
        in_valid = '1;
        tick(); tick();
        check("t5_pre", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_data", 64'(out_data), 64'd0);
        check("t5_chan", 64'(out_chan), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();
        check("t5_restart", 64'(out_chan), 64'd0);
        tick();
        check("t5_second", 64'(out_chan), 64'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'($urandom);
            in_valid  = 8'($urandom);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            sel       = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Out-of-range fixed select on the six-channel instance
        d6_sel = 3'd7;
        #1;
        check("t6_ready", 64'(d6_in_ready), 64'd0);
        tick();
        check("t6_empty", 64'(d6_out_valid), 64'd0);
`ifdef MUX_SEL_CHECK_EN
        check("t6_err", 64'(d6_sel_err), 64'd1);
`endif
        tick();
        check("t6_empty2", 64'(d6_out_valid), 64'd0);
        d6_sel = 3'd2;
        tick();
        check("t6_valid", 64'(d6_out_valid), 64'd1);
        check("t6_data", 64'(d6_out_data), 64'h32);
        check("t6_chan", 64'(d6_out_chan), 64'd2);
`ifdef MUX_SEL_CHECK_EN
        check("t6_err_sticky", 64'(d6_sel_err), 64'd1);
`endif

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_nx1_reg.md
Name: mux_nx1_reg

Overview:
- Parametrised N-channel, W-bit registered selector.
- Generational successor to the combinational 8:1 single-bit mux.
- Each channel carries valid/ready; output is a one-entry registered stage with valid/ready back-pressure.
- Two selection modes: fixed (channel given by sel) and round-robin scan over valid channels; sits between producer blocks and a shared consumer.

Parameters:
- N, 8, number of input channels (2..16).
- W, 8, data width per channel in bits.
- SW, 3, select/channel-index width; must satisfy 2^SW >= N.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel data valid.
- in_ready  output  N  per-channel accept (combinational).
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SW  channel index used in fixed mode.
- out_data  output  W  registered selected data.
- out_valid  output  1  output register holds data.
- out_ready  input  1  consumer accepts out_data.
- out_chan  output  SW  index of channel held in output register.

Behaviour:
- Reset (async, rst_n=0): out_data=0, out_valid=0, out_chan=0, rr pointer ptr=0. Release is synchronous to clk. Reset mid-transfer discards held data without completing the transfer.
- Output stage FSM, 2 states tracked by out_valid:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on (out_ready && !load).
  - FULL -> FULL on (out_ready && load) or !out_ready.
- load_en = !out_valid || out_ready. Full throughput: one word per cycle with simultaneous drain and load.
- Candidate channel c:
  - Fixed mode: c = sel. If sel >= N, no candidate: in_ready all 0, no load.
  - RR mode: first i with in_valid[i]=1, scanning ptr, ptr+1, ..., wrapping N-1 -> 0. None valid -> no candidate.
- in_ready[c] = load_en when a candidate exists; all other in_ready bits are 0. in_ready is never asserted for a non-candidate channel.
- Load occurs when in_valid[c] && in_ready[c]. On the next edge: out_data <= channel c data, out_chan <= c, out_valid <= 1.
- Latency: 1 cycle from accepted input to out_valid.
- ptr updates only on a load in RR mode: ptr <= (c == N-1) ? 0 : c+1. ptr holds in fixed mode.
- While FULL and !out_ready: out_data and out_chan are stable, and sel, mode and in_* changes have no effect on them.
- A mode or sel change takes effect at the next selection. No word is duplicated or dropped.
- in_valid of a non-candidate channel is ignored. Producers hold data until ready.

Optional Feature:
- Macro: MUX_SEL_CHECK_EN.
- Defined:
  - Adds output port sel_err (1 bit, reset 0).
  - sel_err is sticky. It is set on the edge after any cycle with mode=0 and sel >= N. It is cleared only by reset.
- Undefined:
  - Port is absent.
  - Out-of-range sel silently selects nothing, as described in Behaviour.

Test Plan:
1. Fixed mode, N=8, W=8, out_ready=1. Drive channel i data 8'h10+i, all valid, sel stepping 0..7 each cycle -> out_data 8'h10..8'h17 on consecutive cycles, each 1 cycle after its sel, out_chan equal to the sel value.
2. Back-pressure. Fixed sel=3, ch3=8'hA5 valid, out_ready=0 -> out_valid=1, out_data=8'hA5, in_ready[3]=0 while held. Change ch3 to 8'h5A: output stays 8'hA5. Raise out_ready: 8'h5A loads next cycle.
3. Round-robin, all 8 valid, out_ready=1 from reset -> out_chan sequence 0,1,...,7,0 at one word per cycle.
4. Round-robin, only channels 2 and 6 valid -> out_chan 2,6,2,6. Then drop ch6 -> 2,2,2.
5. Reset mid-stream. Assert rst_n=0 asynchronously while out_valid=1 -> out_valid, out_data and out_chan go to 0 immediately. After release, RR restarts from channel 0.
6. Fixed mode, N=6, sel=7 -> in_ready=0, out_valid stays 0. With MUX_SEL_CHECK_EN, sel_err=1 next cycle and stays 1 after sel returns to 2.
